// File: rtl/seq_mult32.sv
// Shift-and-add 64x32 multiplier, free-running, 34-cycle pass.
// Optional registered done pulse when MAIN_DONE_PULSE_EN is defined.
module seq_mult32 (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] X,
    input  logic [31:0] Y,
    output logic [63:0] resultado
`ifdef MAIN_DONE_PULSE_EN
    ,
    output logic        done
`endif
);

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] a;
    logic [31:0] b;
    logic [63:0] p;
    logic [5:0]  cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            LOAD: state_next = RUN;
            RUN:  if (cnt == 6'd31) state_next = DONE;
            DONE: state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a         <= '0;
            b         <= '0;
            p         <= '0;
            cnt       <= '0;
            resultado <= '0;
        end else begin
            unique case (state)
                LOAD: begin
                    a   <= X;
                    b   <= Y;
                    p   <= '0;
                    cnt <= '0;
                end
                RUN: begin
                    // carry out of bit 63 is intentionally dropped
                    if (b[0]) p <= p + a;
                    a   <= a << 1;
                    b   <= b >> 1;
                    cnt <= cnt + 6'd1;
                end
                DONE: begin
                    resultado <= p;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

`ifdef MAIN_DONE_PULSE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done <= 1'b0;
        end else begin
            done <= (state == DONE);
        end
    end
`endif

endmodule

// File: tb/tb_seq_mult32.sv
// Scoreboard bench for seq_mult32: operands captured at LOAD edges,
// products checked when each pass completes and held in between.
module tb_seq_mult32;

    logic        clk;
    logic        reset;
    logic [63:0] X;
    logic [31:0] Y;
    logic [63:0] resultado;
`ifdef MAIN_DONE_PULSE_EN
    logic        done;
`endif

    int          n_vec;
    int          n_bad;
    int          n_pop;
    int          cyc;
    logic [63:0] exp_q[$];
    logic [63:0] cur_exp;

    seq_mult32 dut (
        .clk       (clk),
        .reset     (reset),
        .X         (X),
        .Y         (Y),
        .resultado (resultado)
`ifdef MAIN_DONE_PULSE_EN
        ,
        .done      (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a pass samples X,Y on edge 1+34k and shows X*Y
    // (mod 2^64) from edge 34+34k on.
    always @(posedge clk) begin
        if (!reset) begin
            cyc = 0;
        end else begin
            cyc = cyc + 1;
            if (cyc % 34 == 1) exp_q.push_back(X * {32'd0, Y});
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            cur_exp = '0;
            n_vec++;
            if (resultado !== 64'd0) begin
                n_bad++;
                $display("FAIL reset_hold: got %h want 0", resultado);
            end
        end else begin
            if (cyc > 0 && cyc % 34 == 0) begin
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_empty at cycle %0d", cyc);
                end else begin
                    cur_exp = exp_q.pop_front();
                    n_pop++;
                end
            end
            n_vec++;
            if (resultado !== cur_exp) begin
                n_bad++;
                $display("FAIL product cyc=%0d: got %h want %h",
                         cyc, resultado, cur_exp);
            end
        end
`ifdef MAIN_DONE_PULSE_EN
        n_vec++;
        if (done !== (reset && cyc > 0 && cyc % 34 == 0)) begin
            n_bad++;
            $display("FAIL done_pulse cyc=%0d rst=%b: got %b",
                     cyc, reset, done);
        end
`endif
    end

    task automatic run_pass(input logic [63:0] x, input logic [31:0] y,
                            input int chg);
        X = x;
        Y = y;
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            if (k == chg) begin
                X = {$urandom, $urandom};
                Y = $urandom;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (resultado !== 64'd0) begin
            n_bad++;
            $display("FAIL async_clear: got %h want 0", resultado);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        n_pop   = 0;
        cyc     = 0;
        cur_exp = '0;
        reset   = 1'b0;
        X       = 64'd157;
        Y       = 32'd298;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_pass(64'd157, 32'd298, -1);
        run_pass(64'd157, 32'd298, -1);
        run_pass(64'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_pass(64'h8000_0000_0000_0000, 32'd2, -1);
        run_pass(64'h1_0000_0000, 32'd3, -1);
        run_pass(64'd12345, 32'd0, 10);
        run_pass(64'd7, 32'd6, -1);

        // abort a pass mid-RUN while a nonzero product is showing
        run_pass(64'd157, 32'd298, -1);
        X = 64'd99;
        Y = 32'd5;
        repeat (15) @(negedge clk);
        do_reset();
        run_pass(64'd157, 32'd298, -1);

        for (int i = 0; i < 24; i++) begin
            logic [63:0] rx;
            logic [31:0] ry;
            rx = {$urandom, $urandom};
            ry = $urandom;
            if (i % 4 == 1) rx = 64'($urandom_range(0, 3));
            if (i % 4 == 2) ry = 32'($urandom_range(0, 1));
            run_pass(rx, ry, int'($urandom_range(1, 33)));
        end

        repeat (2) @(negedge clk);
        n_vec++;
        if (n_pop < 30) begin
            n_bad++;
            $display("FAIL pass_count: got %0d want >= 30", n_pop);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
